// File: rtl/ebpc_pkg.sv
// Shared types and constants for the EBPC encoder output path.
// The arbiter FSM encoding and source tag values live here so the bench can decode them.
package ebpc_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_ZNZ,
        ARB_SERVE_BPC
    } arb_state_t;

    localparam logic SRC_ZNZ = 1'b0;
    localparam logic SRC_BPC = 1'b1;

endpackage

// File: rtl/ebpc_out_arbiter_if.sv
// Bundle of the two encoder streams and the merged tagged output of ebpc_out_arbiter.
// Every channel uses valid/ready: a word moves on a rising edge with vld && rdy; the sender holds data and vld stable until then.
interface ebpc_out_arbiter_if #(
    parameter int DATA_W = ebpc_pkg::DATA_W
) ();

    logic [DATA_W-1:0] znz_data_i;
    logic              znz_vld_i;
    logic              znz_rdy_o;
    logic [DATA_W-1:0] bpc_data_i;
    logic              bpc_vld_i;
    logic              bpc_rdy_o;
    logic [DATA_W-1:0] data_o;
    logic              src_o;
    logic              vld_o;
    logic              rdy_i;

    // master: encoder streams plus the downstream sink; slave: the arbiter itself
    modport master (
        output znz_data_i, znz_vld_i, input znz_rdy_o,
        output bpc_data_i, bpc_vld_i, input bpc_rdy_o,
        input  data_o, src_o, vld_o, output rdy_i
    );

    modport slave (
        input  znz_data_i, znz_vld_i, output znz_rdy_o,
        input  bpc_data_i, bpc_vld_i, output bpc_rdy_o,
        output data_o, src_o, vld_o, input rdy_i
    );

endinterface

// File: rtl/ebpc_out_reg.sv
// Single-entry valid/ready register slice carrying the tagged output word.
// It loads whenever it is empty or being drained, so it sustains one word per cycle.
module ebpc_out_reg #(
    parameter int WIDTH = ebpc_pkg::DATA_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_vld_i,
    output logic             in_rdy_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_vld_o,
    input  logic             out_rdy_i
);

    logic can_load;

    assign can_load = !out_vld_o || out_rdy_i;
    assign in_rdy_o = can_load;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_vld_o  <= 1'b0;
            out_data_o <= '0;
        end else if (can_load) begin
            out_vld_o <= in_vld_i;
            // data is only captured with a valid word so an idle slot keeps the last value
            if (in_vld_i) begin
                out_data_o <= in_data_i;
            end
        end
    end

endmodule

// File: rtl/ebpc_out_arbiter.sv
// Round-robin burst arbiter merging the ZNZ and BPC encoder streams onto one tagged output,
// with per-source counters of words accepted downstream.
module ebpc_out_arbiter #(
    parameter int DATA_W    = ebpc_pkg::DATA_W,
    parameter int BURST_LEN = 8,
    parameter int CNT_W     = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    ebpc_out_arbiter_if.slave    bus,
    output logic [CNT_W-1:0]     znz_cnt_o,
    output logic [CNT_W-1:0]     bpc_cnt_o,
    output ebpc_pkg::arb_state_t dbg_state_o,
    output logic                 dbg_prio_o
);

    import ebpc_pkg::*;

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_burst_len
        $error("ebpc_out_arbiter: BURST_LEN must be in 1..256");
    end

    arb_state_t        state_q, state_n;
    logic              prio_q, prio_n;
    logic [BEAT_W-1:0] beat_q, beat_n;

    logic              can_load;
    logic              slot_vld;
    logic [DATA_W:0]   slot_data;
    logic [DATA_W:0]   out_word;
    logic              src_xfer;
    logic              out_xfer;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            prio_q  <= SRC_ZNZ;
            beat_q  <= '0;
        end else begin
            state_q <= state_n;
            prio_q  <= prio_n;
            beat_q  <= beat_n;
        end
    end

    // A burst ends on its last beat or when the granted source runs dry; either way priority flips.
    always_comb begin
        state_n = state_q;
        prio_n  = prio_q;
        beat_n  = beat_q;
        case (state_q)
            ARB_IDLE: begin
                if (bus.znz_vld_i && bus.bpc_vld_i) begin
                    state_n = (prio_q == SRC_BPC) ? ARB_SERVE_BPC : ARB_SERVE_ZNZ;
                end else if (bus.znz_vld_i) begin
                    state_n = ARB_SERVE_ZNZ;
                end else if (bus.bpc_vld_i) begin
                    state_n = ARB_SERVE_BPC;
                end
            end
            ARB_SERVE_ZNZ: begin
                if (!bus.znz_vld_i) begin
                    state_n = ARB_IDLE;
                    prio_n  = SRC_BPC;
                    beat_n  = '0;
                end else if (src_xfer) begin
                    if (beat_q == BEAT_LAST) begin
                        beat_n  = '0;
                        prio_n  = SRC_BPC;
                        state_n = bus.bpc_vld_i ? ARB_SERVE_BPC : ARB_IDLE;
                    end else begin
                        beat_n = beat_q + 1'b1;
                    end
                end
            end
            ARB_SERVE_BPC: begin
                if (!bus.bpc_vld_i) begin
                    state_n = ARB_IDLE;
                    prio_n  = SRC_ZNZ;
                    beat_n  = '0;
                end else if (src_xfer) begin
                    if (beat_q == BEAT_LAST) begin
                        beat_n  = '0;
                        prio_n  = SRC_ZNZ;
                        state_n = bus.znz_vld_i ? ARB_SERVE_ZNZ : ARB_IDLE;
                    end else begin
                        beat_n = beat_q + 1'b1;
                    end
                end
            end
            default: begin
                state_n = ARB_IDLE;
                beat_n  = '0;
            end
        endcase
    end

    // Source ready depends only on the grant and the slice, never on the source's own valid.
    always_comb begin
        bus.znz_rdy_o = 1'b0;
        bus.bpc_rdy_o = 1'b0;
        slot_vld      = 1'b0;
        slot_data     = {SRC_ZNZ, bus.znz_data_i};
        case (state_q)
            ARB_SERVE_ZNZ: begin
                bus.znz_rdy_o = can_load;
                slot_vld      = bus.znz_vld_i;
            end
            ARB_SERVE_BPC: begin
                bus.bpc_rdy_o = can_load;
                slot_vld      = bus.bpc_vld_i;
                slot_data     = {SRC_BPC, bus.bpc_data_i};
            end
            default: begin
                slot_vld = 1'b0;
            end
        endcase
    end

    assign src_xfer = slot_vld && can_load;

    ebpc_out_reg #(
        .WIDTH (DATA_W + 1)
    ) u_out_reg (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_data_i  (slot_data),
        .in_vld_i   (slot_vld),
        .in_rdy_o   (can_load),
        .out_data_o (out_word),
        .out_vld_o  (bus.vld_o),
        .out_rdy_i  (bus.rdy_i)
    );

    assign bus.data_o = out_word[DATA_W-1:0];
    assign bus.src_o  = out_word[DATA_W];
    assign out_xfer   = bus.vld_o && bus.rdy_i;

    // A clear that lands on a transfer still counts that word for its source.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            znz_cnt_o <= '0;
            bpc_cnt_o <= '0;
        end else if (clear_i) begin
            znz_cnt_o <= CNT_W'(out_xfer && (bus.src_o == SRC_ZNZ));
            bpc_cnt_o <= CNT_W'(out_xfer && (bus.src_o == SRC_BPC));
        end else if (out_xfer) begin
            if (bus.src_o == SRC_BPC) begin
                bpc_cnt_o <= bpc_cnt_o + 1'b1;
            end else begin
                znz_cnt_o <= znz_cnt_o + 1'b1;
            end
        end
    end

    assign dbg_state_o = state_q;
    assign dbg_prio_o  = prio_q;

endmodule

// File: tb/tb_ebpc_out_arbiter.sv
// Bench for ebpc_out_arbiter: a BURST_LEN=8/32-bit-counter instance and a BURST_LEN=1/4-bit-counter
// instance share one set of driver signals, selected by sel, checked against a burst-level model.
module tb_ebpc_out_arbiter;
  import ebpc_pkg::*;

  localparam int DW = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic clear = 1'b0;
  logic sel = 1'b0;
  logic [DW-1:0] znz_data = '0;
  logic [DW-1:0] bpc_data = '0;
  logic znz_vld = 1'b0;
  logic bpc_vld = 1'b0;
  logic rdy = 1'b0;

  ebpc_out_arbiter_if #(.DATA_W(DW)) bus_a ();
  ebpc_out_arbiter_if #(.DATA_W(DW)) bus_b ();

  logic [31:0] cnt_a_znz, cnt_a_bpc;
  logic [3:0] cnt_b_znz, cnt_b_bpc;
  arb_state_t st_a, st_b;
  logic prio_a, prio_b;

  ebpc_out_arbiter #(.DATA_W(DW), .BURST_LEN(8), .CNT_W(32)) dut_a (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .bus(bus_a),
    .znz_cnt_o(cnt_a_znz), .bpc_cnt_o(cnt_a_bpc), .dbg_state_o(st_a), .dbg_prio_o(prio_a)
  );

  ebpc_out_arbiter #(.DATA_W(DW), .BURST_LEN(1), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .bus(bus_b),
    .znz_cnt_o(cnt_b_znz), .bpc_cnt_o(cnt_b_bpc), .dbg_state_o(st_b), .dbg_prio_o(prio_b)
  );

  assign bus_a.znz_data_i = znz_data;
  assign bus_a.bpc_data_i = bpc_data;
  assign bus_a.znz_vld_i = znz_vld && !sel;
  assign bus_a.bpc_vld_i = bpc_vld && !sel;
  assign bus_a.rdy_i = rdy && !sel;
  assign bus_b.znz_data_i = znz_data;
  assign bus_b.bpc_data_i = bpc_data;
  assign bus_b.znz_vld_i = znz_vld && sel;
  assign bus_b.bpc_vld_i = bpc_vld && sel;
  assign bus_b.rdy_i = rdy && sel;

  logic o_znz_rdy, o_bpc_rdy, o_vld, o_src, o_prio;
  logic [DW-1:0] o_data;
  logic [31:0] o_znz_cnt, o_bpc_cnt;
  arb_state_t o_state;

  assign o_znz_rdy = sel ? bus_b.znz_rdy_o : bus_a.znz_rdy_o;
  assign o_bpc_rdy = sel ? bus_b.bpc_rdy_o : bus_a.bpc_rdy_o;
  assign o_vld = sel ? bus_b.vld_o : bus_a.vld_o;
  assign o_src = sel ? bus_b.src_o : bus_a.src_o;
  assign o_data = sel ? bus_b.data_o : bus_a.data_o;
  assign o_znz_cnt = sel ? {28'd0, cnt_b_znz} : cnt_a_znz;
  assign o_bpc_cnt = sel ? {28'd0, cnt_b_bpc} : cnt_a_bpc;
  assign o_state = sel ? st_b : st_a;
  assign o_prio = sel ? prio_b : prio_a;

  // scoreboard state and reference-model bookkeeping per instance
  int passed = 0;
  int total = 0;
  int mcnt[2][2];
  bit mprio[2];
  int first_vld;
  int stall_seen;
  int fire_cyc[$];
  arb_state_t state_log[$];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mprio[d] = 1'b0;
      mcnt[d][0] = 0;
      mcnt[d][1] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear = 1'b0;
    znz_vld = 1'b0;
    bpc_vld = 1'b0;
    rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // driver + scoreboard: both sources stay valid while they hold words
  task automatic run_stream(input int n_znz, input int n_bpc, input int rdy_pct, input bit seq_data,
                            input int stall_at, input int stall_len, input int clear_at);
    logic [DW:0] exp_q[$];
    logic [DW-1:0] zq[$];
    logic [DW-1:0] bq[$];
    logic [DW:0] prev_word;
    int rem[2];
    int cur, bl, n, zi, bi, s, fires, stall_left, cyc, guard, limit;
    bit znz_fire, bpc_fire, hold;

    s = sel ? 1 : 0;
    bl = sel ? 1 : 8;
    for (int i = 0; i < n_znz; i++) zq.push_back(seq_data ? DW'(i + 1) : DW'($urandom_range(0, 255)));
    for (int i = 0; i < n_bpc; i++) bq.push_back(seq_data ? DW'(8'h80 + i) : DW'($urandom_range(0, 255)));

    // reference: alternate whole bursts of up to bl words, skipping an exhausted source
    rem[0] = n_znz;
    rem[1] = n_bpc;
    cur = mprio[s] ? 1 : 0;
    zi = 0;
    bi = 0;
    while (rem[0] + rem[1] > 0) begin
      n = (rem[cur] < bl) ? rem[cur] : bl;
      for (int k = 0; k < n; k++) begin
        if (cur == 0) begin
          exp_q.push_back({1'b0, zq[zi]});
          zi++;
        end else begin
          exp_q.push_back({1'b1, bq[bi]});
          bi++;
        end
      end
      rem[cur] -= n;
      cur = 1 - cur;
    end
    mprio[s] = (cur == 1);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k == clear_at) begin
        for (int d = 0; d < 2; d++) begin
          mcnt[d][0] = 0;
          mcnt[d][1] = 0;
        end
      end
      mcnt[s][exp_q[k][DW] ? 1 : 0]++;
    end

    first_vld = -1;
    stall_seen = 0;
    fire_cyc.delete();
    state_log.delete();
    fires = 0;
    stall_left = 0;
    cyc = 0;
    guard = 0;
    hold = 1'b0;
    prev_word = '0;
    limit = 40 * (n_znz + n_bpc + 2) + 50;

    while (exp_q.size() > 0 && guard < limit) begin
      znz_vld = (zq.size() > 0);
      znz_data = (zq.size() > 0) ? zq[0] : '0;
      bpc_vld = (bq.size() > 0);
      bpc_data = (bq.size() > 0) ? bq[0] : '0;
      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else begin
        rdy = ($urandom_range(0, 99) < rdy_pct);
      end

      @(negedge clk);
      if (hold) begin
        total++;
        if (o_vld !== 1'b1 || {o_src, o_data} !== prev_word) begin
          $display("FAIL stall_stable: got vld=%0b word=%0h required vld=1 word=%0h", o_vld, {o_src, o_data}, prev_word);
        end else passed++;
      end
      if (o_vld && !rdy) begin
        stall_seen++;
        total++;
        if (o_znz_rdy !== 1'b0 || o_bpc_rdy !== 1'b0) begin
          $display("FAIL backpressure_rdy: got znz_rdy=%0b bpc_rdy=%0b required 0/0", o_znz_rdy, o_bpc_rdy);
        end else passed++;
      end
      if (o_state == ARB_IDLE) begin
        total++;
        if (o_znz_rdy !== 1'b0 || o_bpc_rdy !== 1'b0) begin
          $display("FAIL idle_rdy: got znz_rdy=%0b bpc_rdy=%0b required 0/0", o_znz_rdy, o_bpc_rdy);
        end else passed++;
      end
      if (first_vld < 0 && o_vld) first_vld = cyc;
      state_log.push_back(o_state);
      znz_fire = znz_vld && o_znz_rdy;
      bpc_fire = bpc_vld && o_bpc_rdy;
      hold = o_vld && !rdy;
      prev_word = {o_src, o_data};
      if (o_vld && rdy) begin
        total++;
        if ({o_src, o_data} !== exp_q[0]) begin
          $display("FAIL scoreboard: got src=%0b data=%0h required src=%0b data=%0h",
                   o_src, o_data, exp_q[0][DW], exp_q[0][DW-1:0]);
        end else passed++;
        void'(exp_q.pop_front());
        fire_cyc.push_back(cyc);
        if (fires == clear_at) clear = 1'b1;
        fires++;
        if (fires == stall_at) stall_left = stall_len;
      end

      @(posedge clk);
      #1;
      clear = 1'b0;
      cyc++;
      guard++;
      if (znz_fire) void'(zq.pop_front());
      if (bpc_fire) void'(bq.pop_front());
    end

    total++;
    if (exp_q.size() != 0) begin
      $display("FAIL stream_timeout: got %0d words outstanding required 0", exp_q.size());
    end else passed++;

    znz_vld = 1'b0;
    bpc_vld = 1'b0;
    rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (o_vld !== 1'b0 || o_state !== ARB_IDLE) begin
      $display("FAIL stream_drain: got vld=%0b state=%0d required vld=0 state=IDLE", o_vld, o_state);
    end else passed++;
    total++;
    if (o_prio !== mprio[s]) begin
      $display("FAIL stream_prio: got %0b required %0b", o_prio, mprio[s]);
    end else passed++;
    total++;
    if (o_znz_cnt !== (sel ? 32'(mcnt[s][0] % 16) : 32'(mcnt[s][0]))) begin
      $display("FAIL znz_cnt: got %0d required %0d", o_znz_cnt, sel ? mcnt[s][0] % 16 : mcnt[s][0]);
    end else passed++;
    total++;
    if (o_bpc_cnt !== (sel ? 32'(mcnt[s][1] % 16) : 32'(mcnt[s][1]))) begin
      $display("FAIL bpc_cnt: got %0d required %0d", o_bpc_cnt, sel ? mcnt[s][1] % 16 : mcnt[s][1]);
    end else passed++;
    rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    znz_vld = 1'b0;
    bpc_vld = 1'b0;
    rdy = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #1;
      total++;
      if (o_vld !== 1'b0 || o_data !== '0 || o_src !== 1'b0 || o_znz_rdy !== 1'b0 || o_bpc_rdy !== 1'b0) begin
        $display("FAIL reset_outputs: got vld=%0b data=%0h src=%0b rdy=%0b/%0b required all 0",
                 o_vld, o_data, o_src, o_znz_rdy, o_bpc_rdy);
      end else passed++;
      total++;
      if (o_znz_cnt !== 32'd0 || o_bpc_cnt !== 32'd0 || o_state !== ARB_IDLE || o_prio !== 1'b0) begin
        $display("FAIL reset_state: got cnt=%0d/%0d state=%0d prio=%0b required 0/0 IDLE 0",
                 o_znz_cnt, o_bpc_cnt, o_state, o_prio);
      end else passed++;
    end
    sel = 1'b0;
    do_reset();
  endtask

  task automatic test_single_source();
    do_reset();
    sel = 1'b0;
    run_stream(5, 0, 100, 1'b1, -1, 0, -1);
    total++;
    if (first_vld != 2) begin
      $display("FAIL single_latency: got %0d cycles required 2", first_vld);
    end else passed++;
  endtask

  task automatic test_both_bursts();
    do_reset();
    sel = 1'b0;
    run_stream(20, 20, 100, 1'b0, -1, 0, -1);
    total++;
    if (fire_cyc.size() < 36 || fire_cyc[35] - fire_cyc[0] != 35) begin
      $display("FAIL burst_gapless: got span %0d required 35",
               (fire_cyc.size() < 36) ? -1 : fire_cyc[35] - fire_cyc[0]);
    end else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    sel = 1'b0;
    run_stream(12, 12, 100, 1'b0, 4, 5, -1);
    total++;
    if (stall_seen != 5) begin
      $display("FAIL stall_cycles: got %0d required 5", stall_seen);
    end else passed++;
  endtask

  task automatic test_early_release();
    bit found;
    do_reset();
    sel = 1'b0;
    run_stream(4, 0, 100, 1'b0, -1, 0, -1);
    run_stream(12, 3, 100, 1'b0, -1, 0, -1);
    found = 1'b0;
    for (int i = 0; i + 2 < state_log.size(); i++) begin
      if (state_log[i] == ARB_SERVE_BPC && state_log[i+1] == ARB_IDLE && state_log[i+2] == ARB_SERVE_ZNZ) found = 1'b1;
    end
    total++;
    if (!found) begin
      $display("FAIL release_path: got no BPC->IDLE->ZNZ sequence required one");
    end else passed++;
    run_stream(10, 10, 100, 1'b0, -1, 0, -1);
  endtask

  task automatic test_clear();
    do_reset();
    sel = 1'b0;
    run_stream(3, 5, 100, 1'b0, -1, 0, 7);
  endtask

  task automatic test_burst1_alternation();
    do_reset();
    sel = 1'b1;
    run_stream(6, 6, 100, 1'b0, -1, 0, -1);
    total++;
    if (fire_cyc.size() < 12 || fire_cyc[11] - fire_cyc[0] != 11) begin
      $display("FAIL alternation_rate: got span %0d required 11",
               (fire_cyc.size() < 12) ? -1 : fire_cyc[11] - fire_cyc[0]);
    end else passed++;
    sel = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    sel = 1'b1;
    run_stream(17, 0, 100, 1'b0, -1, 0, -1);
    sel = 1'b0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    sel = 1'b0;
    znz_data = 8'hA5;
    bpc_data = 8'h5A;
    znz_vld = 1'b1;
    bpc_vld = 1'b1;
    rdy = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (o_vld !== 1'b1) begin
      $display("FAIL midstream_busy: got vld=%0b required 1", o_vld);
    end else passed++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    total++;
    if (o_vld !== 1'b0 || o_data !== '0 || o_src !== 1'b0 || o_znz_rdy !== 1'b0 || o_bpc_rdy !== 1'b0 ||
        o_znz_cnt !== 32'd0 || o_bpc_cnt !== 32'd0 || o_prio !== 1'b0) begin
      $display("FAIL midstream_reset: got vld=%0b data=%0h src=%0b cnt=%0d/%0d prio=%0b required all 0",
               o_vld, o_data, o_src, o_znz_cnt, o_bpc_cnt, o_prio);
    end else passed++;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (o_vld !== 1'b1 || o_src !== SRC_ZNZ || o_data !== 8'hA5) begin
      $display("FAIL midstream_first_grant: got vld=%0b src=%0b data=%0h required 1 0 a5", o_vld, o_src, o_data);
    end else passed++;
    do_reset();
  endtask

  task automatic test_random();
    int nz, nb, pct, st, cl;
    do_reset();
    for (int it = 0; it < 8; it++) begin
      sel = it[0];
      nz = $urandom_range(0, 20);
      nb = $urandom_range(0, 20);
      pct = $urandom_range(40, 100);
      st = $urandom_range(1, 10);
      cl = ($urandom_range(0, 1) == 1 && nz + nb > 0) ? $urandom_range(0, nz + nb - 1) : -1;
      run_stream(nz, nb, pct, 1'b0, st, $urandom_range(0, 4), cl);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_both_bursts();
    test_stall();
    test_early_release();
    test_clear();
    test_burst1_alternation();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ebpc_out_arbiter.md
# ebpc_out_arbiter

Shares one output handshake port between the two compressed streams of `ebpc_encoder`, the zero/non-zero (ZNZ) stream and the bit-plane (BPC) stream, so both can be written through a single memory/DMA write channel. Arbitration is round-robin in bursts of up to `BURST_LEN` words. Every output word carries a source tag, and per-source word counters are exposed for the stream-length bookkeeping done by the host.

## Interface
- `DATA_W`, default `ebpc_pkg::DATA_W` (8): word width of both encoder streams and of the output.
- `BURST_LEN`, default 8: maximum words forwarded per grant; legal range 1..256.
- `CNT_W`, default 32: width of the per-source word counters.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `clear_i`  in  1  synchronous clear of both word counters; does not affect arbitration.
- `znz_data_i`  in  `DATA_W`  ZNZ stream data from the encoder.
- `znz_vld_i`  in  1  ZNZ valid.
- `znz_rdy_o`  out  1  ZNZ ready.
- `bpc_data_i`  in  `DATA_W`  BPC stream data from the encoder.
- `bpc_vld_i`  in  1  BPC valid.
- `bpc_rdy_o`  out  1  BPC ready.
- `data_o`  out  `DATA_W`  merged output data.
- `src_o`  out  1  source tag of `data_o`: 0 = ZNZ, 1 = BPC.
- `vld_o`  out  1  output valid.
- `rdy_i`  in  1  output ready.
- `znz_cnt_o`  out  `CNT_W`  ZNZ words accepted at the output since reset/clear.
- `bpc_cnt_o`  out  `CNT_W`  BPC words accepted at the output since reset/clear.

## Operation
- **Handshakes.** A transfer happens on any edge where vld && rdy. Sources hold data/valid until accepted. The arbiter never drops `vld_o` or changes `data_o`/`src_o` while `vld_o && !rdy_i`.
- **Output stage.** One register stage (data, tag, valid).
  - `can_load = !vld_o || rdy_i`.
  - Source ready = `can_load` && granted to that source.
- **FSM states:** IDLE, SERVE_ZNZ, SERVE_BPC. `prio` bit: 0 = ZNZ first.
- **IDLE:**
  - Both valid: go to the state given by `prio`.
  - Only one valid: go to that source's state.
  - Neither valid: stay.
  - The grant is registered; no source ready is asserted in IDLE.
- **SERVE_x, on each source transfer:** `beat_cnt` increments.
  - On the transfer with `beat_cnt == BURST_LEN-1`: reset `beat_cnt` and set `prio` to the other source.
  - If the other source is valid in that cycle, go straight to SERVE_other. Otherwise go to IDLE.
- **SERVE_x with `x_vld_i == 0`:** early release. Go to IDLE, set `prio` to the other source, clear `beat_cnt`.
- **Counters.**
  - An output transfer increments the counter selected by `src_o`, wrapping modulo 2^`CNT_W`.
  - If `clear_i` coincides with a transfer, the counter is loaded with 1 for that source and 0 for the other.
- **Reset.** `rst_i` mid-operation discards the output register content and any partial burst. The upstream encoder is reset by the same system reset.

## Timing
- **Reset values:**
  - `vld_o`=0, `data_o`=0, `src_o`=0.
  - `znz_rdy_o`=`bpc_rdy_o`=0.
  - `znz_cnt_o`=`bpc_cnt_o`=0.
  - FSM = IDLE, `prio`=0, `beat_cnt`=0.
- **Latency.** Source transfer at edge N gives `vld_o`=1 with that word after edge N, so it is acceptable at edge N+1.
- **Grant cost.** Leaving IDLE costs one cycle. A direct burst-to-burst switch costs zero cycles.
- **Throughput.** Full rate (1 word/cycle) while `rdy_i`=1 and the granted source is valid.
- **Backpressure.** `rdy_i`=0 with `vld_o`=1 gives `x_rdy_o`=0 the same cycle (combinational through `can_load`).
- **Counter timing.** Counters update on the edge of the output transfer and are registered outputs.
- **`BURST_LEN`=1.** Strict alternation while both sources are valid.

## Structure
- `ebpc_pkg` additions:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_SERVE_ZNZ, ARB_SERVE_BPC} arb_state_t`.
  - `localparam SRC_ZNZ = 1'b0, SRC_BPC = 1'b1`.
- One sub-module, `ebpc_out_reg`: the single-entry handshake register slice (data+tag, parameter `DATA_W+1`).
- FSM, burst counter and word counters live in the top module.

## Test plan
- **Single source.** Only ZNZ valid, words 0x01..0x05, `rdy_i`=1.
  - Output sequence is 0x01..0x05 with `src_o`=0.
  - First `vld_o` appears 2 cycles after `znz_vld_i` rises (IDLE grant + register).
  - `znz_cnt_o`=5, `bpc_cnt_o`=0.
- **Both sources, `BURST_LEN`=8.** Each source presents 20 words continuously.
  - Output is ZNZ×8, BPC×8, ZNZ×8, BPC×8, ZNZ×4, BPC×4.
  - No idle cycles between bursts.
  - Final counts: 20/20.
- **Output stall.** `rdy_i` held low for 5 cycles mid-burst.
  - `data_o`/`src_o` are stable throughout the stall.
  - Source readies are low during the stall.
  - No words are lost or duplicated (scoreboard check against per-source expected queues).
- **Early release.** BPC is granted and goes invalid after 3 words while ZNZ is valid.
  - FSM passes through IDLE and then serves ZNZ.
  - `prio` now favours ZNZ; the BPC partial burst does not count toward its next burst.
- **Clear and wrap.**
  - `clear_i` in the same cycle as a BPC output transfer gives `bpc_cnt_o`=1 and `znz_cnt_o`=0.
  - With `CNT_W`=4, 17 ZNZ words give `znz_cnt_o`=1.
- **Reset mid-stream.** `rst_i` asserted while `vld_o`=1.
  - All outputs return to their reset values on the next edge.
  - After release, the first grant goes to ZNZ when both sources are valid.
